// File: rtl/connect4_pkg.sv
// connect4_pkg: shared definitions for the Connect-Four board logic.
//   - Cell codes written into the board register (01 is never a cell code).
//   - Game result codes reported on board_writer.result.
//   - Default board geometry.
//   - Write-side FSM state encoding.
package connect4_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLUE  = 2'b10;
  localparam logic [1:0] CELL_RED   = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_BLUE = 2'b10;
  localparam logic [1:0] RES_RED  = 2'b11;
  localparam logic [1:0] RES_DRAW = 2'b01;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 7;
  localparam int DEF_CW   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Cell code for the player whose turn it is (turn 0 = blue, 1 = red).
  function automatic logic [1:0] player_cell(input logic turn);
    return turn ? CELL_RED : CELL_BLUE;
  endfunction

endpackage

// File: rtl/board_writer.sv
// board_writer: write side of the Connect-Four board.
//   Accepts a column drop, scans the column bottom-up one row per cycle for
//   the lowest empty cell, writes the current player's code there, then waits
//   one cycle for the external checker array before sampling its win code.
//   Alternates turns and declares a draw when the board fills with no win.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   move_valid    drop request; accepted when move_valid && move_ready
//   move_col      target column (CW bits)
//   move_ready    high only while idle
//   move_done     one-cycle pulse: piece written
//   move_err      one-cycle pulse: move rejected (bad or full column)
//   board         flattened board, cell (r,c) at bits [2*(r*COLS+c) +: 2]
//   turn          0 = blue to move, 1 = red to move
//   win_in        aggregated checker result: 00 none, 10 blue, 11 red
//   game_over     game ended, moves ignored
//   result        00 in play, 10 blue win, 11 red win, 01 draw
//   new_game      clears the game, honoured when idle or over
//   undo          (only with BOARD_WRITER_UNDO_EN) take back the last move
//
// Build option: define BOARD_WRITER_UNDO_EN to add the single-level undo.
module board_writer
  import connect4_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int CW   = DEF_CW
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef BOARD_WRITER_UNDO_EN
  input  logic                     undo,
`endif
  input  logic                     move_valid,
  input  logic [CW-1:0]            move_col,
  output logic                     move_ready,
  output logic                     move_done,
  output logic                     move_err,
  output logic [2*ROWS*COLS-1:0]   board,
  output logic                     turn,
  input  logic [1:0]               win_in,
  output logic                     game_over,
  output logic [1:0]               result,
  input  logic                     new_game
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MW    = $clog2(CELLS + 1);

  localparam logic [RW-1:0] ROW_TOP  = RW'(ROWS - 1);
  localparam logic [CW:0]   COLS_LIM = (CW + 1)'(COLS);
  localparam logic [MW-1:0] CNT_FULL = MW'(CELLS);

  state_t                   state_reg,  state_next;
  logic [2*CELLS-1:0]       board_reg,  board_next;
  logic                     turn_reg,   turn_next;
  logic [1:0]               result_reg, result_next;
  logic [MW-1:0]            cnt_reg,    cnt_next;
  logic [RW-1:0]            row_reg,    row_next;
  logic [CW-1:0]            col_reg,    col_next;
  logic                     done_reg,   done_next;
  logic                     err_reg,    err_next;
  logic                     clear_game;

  // Bit offset of the cell currently addressed by the scan.
  logic [IW-1:0] scan_idx;
  logic [IW:0]   scan_bit;
  assign scan_idx = IW'(row_reg) * IW'(COLS) + IW'(col_reg);
  assign scan_bit = {scan_idx, 1'b0};

`ifdef BOARD_WRITER_UNDO_EN
  logic          hist_valid_reg, hist_valid_next;
  logic [IW:0]   hist_bit_reg,   hist_bit_next;
`endif

  always_comb begin
    state_next  = state_reg;
    board_next  = board_reg;
    turn_next   = turn_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    clear_game  = 1'b0;
`ifdef BOARD_WRITER_UNDO_EN
    hist_valid_next = hist_valid_reg;
    hist_bit_next   = hist_bit_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (new_game) begin
          // A simultaneous move is dropped.
          clear_game = 1'b1;
`ifdef BOARD_WRITER_UNDO_EN
        end else if (undo) begin
          // Undo outranks a move in the same cycle even with no history.
          if (hist_valid_reg) begin
            board_next[hist_bit_reg +: 2] = CELL_EMPTY;
            turn_next       = ~turn_reg;
            cnt_next        = cnt_reg - MW'(1);
            hist_valid_next = 1'b0;
          end
`endif
        end else if (move_valid) begin
          if ({1'b0, move_col} >= COLS_LIM) begin
            err_next = 1'b1;
          end else begin
            col_next   = move_col;
            row_next   = '0;
            state_next = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        if (board_reg[scan_bit +: 2] == CELL_EMPTY) begin
          state_next = ST_WRITE;
        end else if (row_reg == ROW_TOP) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          row_next = row_reg + RW'(1);
        end
      end

      ST_WRITE: begin
        board_next[scan_bit +: 2] = player_cell(turn_reg);
        if (cnt_reg != CNT_FULL) begin
          cnt_next = cnt_reg + MW'(1);
        end
        turn_next  = ~turn_reg;
        // done is registered here so it is high during the settle cycle.
        done_next  = 1'b1;
        state_next = ST_SETTLE;
`ifdef BOARD_WRITER_UNDO_EN
        hist_valid_next = 1'b1;
        hist_bit_next   = scan_bit;
`endif
      end

      ST_SETTLE: begin
        // Checkers have had a full cycle to see the new board.
        if (win_in[1]) begin
          result_next = win_in;
          state_next  = ST_OVER;
        end else if (cnt_reg == CNT_FULL) begin
          result_next = RES_DRAW;
          state_next  = ST_OVER;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_OVER: begin
        if (new_game) begin
          clear_game = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear_game) begin
      state_reg  <= ST_IDLE;
      board_reg  <= '0;
      turn_reg   <= 1'b0;
      result_reg <= RES_NONE;
      cnt_reg    <= '0;
      row_reg    <= '0;
      col_reg    <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
`ifdef BOARD_WRITER_UNDO_EN
      hist_valid_reg <= 1'b0;
      hist_bit_reg   <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      board_reg  <= board_next;
      turn_reg   <= turn_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
`ifdef BOARD_WRITER_UNDO_EN
      hist_valid_reg <= hist_valid_next;
      hist_bit_reg   <= hist_bit_next;
`endif
    end
  end

`ifdef BOARD_WRITER_UNDO_EN
  assign move_ready = (state_reg == ST_IDLE) && !undo;
`else
  assign move_ready = (state_reg == ST_IDLE);
`endif
  assign move_done  = done_reg;
  assign move_err   = err_reg;
  assign board      = board_reg;
  assign turn       = turn_reg;
  assign game_over  = (state_reg == ST_OVER);
  assign result     = result_reg;

endmodule

// File: tb/tb_board_writer.sv
module tb_board_writer;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 move_valid = 1'b0;
  logic [2:0]           move_col = 3'd0;
  logic                 move_ready;
  logic                 move_done;
  logic                 move_err;
  logic [2*CELLS-1:0]   board;
  logic                 turn;
  logic [1:0]           win_in = 2'b00;
  logic                 game_over;
  logic [1:0]           result;
  logic                 new_game = 1'b0;
`ifdef BOARD_WRITER_UNDO_EN
  logic                 undo = 1'b0;
`endif

  board_writer #(.ROWS(ROWS), .COLS(COLS), .CW(3)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef BOARD_WRITER_UNDO_EN
    .undo       (undo),
`endif
    .move_valid (move_valid),
    .move_col   (move_col),
    .move_ready (move_ready),
    .move_done  (move_done),
    .move_err   (move_err),
    .board      (board),
    .turn       (turn),
    .win_in     (win_in),
    .game_over  (game_over),
    .result     (result),
    .new_game   (new_game)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Behavioural game model: a grid, column heights and game status.
  logic [1:0] grid [ROWS][COLS];
  int         height [COLS];
  bit         m_turn;
  int         m_moves;
  logic [1:0] m_result;
  bit         m_over;
  bit         h_valid;
  int         h_col;

  // Pulse schedule: negedge (by posedge count) at which a pulse is visible.
  int  done_due = -1;
  int  err_due  = -1;
  bit  active    = 1'b0;
  bit  chk_state = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        grid[r][c] = 2'b00;
    for (int c = 0; c < COLS; c++) height[c] = 0;
    m_turn = 1'b0; m_moves = 0; m_result = 2'b00; m_over = 1'b0; h_valid = 1'b0; h_col = 0;
  endtask

  function automatic logic [2*CELLS-1:0] model_flat();
    logic [2*CELLS-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        f[2*(r*COLS+c) +: 2] = grid[r][c];
    return f;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (active) begin
      check("move_done", {127'b0, move_done}, {127'b0, (cyc == done_due)});
      check("move_err",  {127'b0, move_err},  {127'b0, (cyc == err_due)});
      if (chk_state) begin
        check("board",      {44'b0, board},      {44'b0, model_flat()});
        check("turn",       {127'b0, turn},      {127'b0, m_turn});
        check("result",     {126'b0, result},    {126'b0, m_result});
        check("game_over",  {127'b0, game_over}, {127'b0, m_over});
        check("move_ready", {127'b0, move_ready},{127'b0, !m_over});
      end
    end
  end

  task automatic do_move(input int col, input logic [1:0] wv);
    int e, lat, r;
    string what;
    if (m_over) begin
      @(negedge clk);
      move_valid = 1'b1; move_col = col[2:0];
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      $display("move col=%0d ignored (game over) result=%0b", col, m_result);
      return;
    end
    @(negedge clk);
    chk_state  = 1'b0;
    move_valid = 1'b1; move_col = col[2:0]; win_in = wv;
    e = cyc + 1;
    r = -1;
    if (col >= COLS) begin
      lat = 1; err_due = e + lat - 1; what = "bad column";
    end else if (height[col] == ROWS) begin
      lat = ROWS + 1; err_due = e + lat - 1; what = "column full";
    end else begin
      r = height[col]; lat = r + 3; done_due = e + lat - 1; what = "written";
    end
    @(negedge clk);
    move_valid = 1'b0;
    repeat (lat) @(negedge clk);
    if (r >= 0) begin
      grid[r][col] = m_turn ? 2'b11 : 2'b10;
      height[col]++;
      m_moves++;
      m_turn = ~m_turn;
      h_valid = 1'b1; h_col = col;
      if (wv[1]) begin m_result = wv; m_over = 1'b1; end
      else if (m_moves == CELLS) begin m_result = 2'b01; m_over = 1'b1; end
    end
    win_in = 2'b00; done_due = -1; err_due = -1;
    chk_state = 1'b1;
    $display("move col=%0d %s row=%0d latency=%0d turn=%0d result=%0b", col, what, r, lat, m_turn, m_result);
  endtask

  task automatic do_new_game(input bit with_move);
    @(negedge clk);
    chk_state = 1'b0;
    new_game = 1'b1;
    if (with_move) begin move_valid = 1'b1; move_col = 3'd0; end
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0;
    model_reset();
    chk_state = 1'b1;
    $display("new_game with_move=%0d", with_move);
  endtask

`ifdef BOARD_WRITER_UNDO_EN
  task automatic do_undo(input bit with_move);
    @(negedge clk);
    chk_state = 1'b0;
    undo = 1'b1;
    if (with_move) begin move_valid = 1'b1; move_col = 3'd1; end
    @(negedge clk);
    undo = 1'b0; move_valid = 1'b0;
    if (h_valid && !m_over) begin
      height[h_col]--;
      grid[height[h_col]][h_col] = 2'b00;
      m_turn = ~m_turn; m_moves--; h_valid = 1'b0;
    end
    chk_state = 1'b1;
    $display("undo with_move=%0d turn=%0d moves=%0d", with_move, m_turn, m_moves);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog time budget exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [1:0] wv;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    active = 1'b1; chk_state = 1'b1;
    @(negedge clk);
    check("reset_board",   {44'b0, board}, 128'd0);
    check("reset_turn",    {127'b0, turn}, 128'd0);
    check("reset_result",  {126'b0, result}, 128'd0);
    check("reset_over",    {127'b0, game_over}, 128'd0);
    check("reset_ready",   {127'b0, move_ready}, 128'd1);
    $display("reset done");

    // First drop in an empty column lands at (0,3), done three cycles later.
    do_move(3, 2'b00);
    check("first_cell03", {126'b0, board[7:6]}, 128'h2);
    check("first_turn",   {127'b0, turn}, 128'd1);

    // Fill column 3, then one more drop must be rejected.
    do_new_game(1'b0);
    for (int i = 0; i < ROWS; i++) do_move(3, 2'b00);
    check("col3_top_red", {126'b0, board[77:76]}, 128'h3);
    do_move(3, 2'b00);
    check("full_turn", {127'b0, turn}, 128'd0);
    do_move(7, 2'b00);

    // Blue builds a horizontal four while red stacks column 6.
    do_new_game(1'b0);
    for (int i = 0; i < 3; i++) begin
      do_move(i, 2'b00);
      do_move(6, 2'b00);
    end
    do_move(3, 2'b10);
    check("win_result", {126'b0, result}, 128'h2);
    check("win_over",   {127'b0, game_over}, 128'd1);
    do_move(4, 2'b00);
    do_move(7, 2'b00);

    // Reset while scanning a column of height 3.
    do_new_game(1'b0);
    for (int i = 0; i < 3; i++) do_move(0, 2'b00);
    @(negedge clk);
    chk_state = 1'b0;
    move_valid = 1'b1; move_col = 3'd0;
    e = cyc + 1;
    done_due = e + 5;
    @(negedge clk);
    move_valid = 1'b0;
    rst = 1'b1; done_due = -1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_state = 1'b1;
    check("rst_scan_board", {44'b0, board}, 128'd0);
    check("rst_scan_ready", {127'b0, move_ready}, 128'd1);
    $display("reset during scan");
    repeat (6) @(negedge clk);

    // new_game beats a simultaneous move.
    do_new_game(1'b1);

    // Random fill to a draw with the checker reporting no win.
    while (!m_over) do_move($urandom_range(0, 7), 2'b00);
    check("draw_result", {126'b0, result}, 128'h1);
    check("draw_moves",  m_moves, CELLS);

    // Random games with occasional injected wins.
    for (int g = 0; g < 4; g++) begin
      do_new_game(1'b0);
      for (int m = 0; m < 30 && !m_over; m++) begin
        wv = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 2'b11 : 2'b10) : 2'b00;
        do_move($urandom_range(0, 7), wv);
      end
      do_move($urandom_range(0, 6), 2'b00);
      do_new_game(1'b0);
    end

`ifdef BOARD_WRITER_UNDO_EN
    do_new_game(1'b0);
    do_move(2, 2'b00);
    do_undo(1'b0);
    check("undo_cell02", {126'b0, board[5:4]}, 128'd0);
    check("undo_turn",   {127'b0, turn}, 128'd0);
    do_undo(1'b0);
    do_move(4, 2'b00);
    do_move(4, 2'b00);
    do_undo(1'b1);
    do_move(5, 2'b00);
`endif

    repeat (3) @(negedge clk);
    active = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write side of the Connect-Four board: accepts a column drop from the player input logic and owns the board register.
- Finds the lowest empty cell in the column by a sequential bottom-up scan, then writes the current player's cell code there.
- Exposes the flattened board to the four-in-a-row checker array and samples the array's aggregated win code to end the game.
- Alternates turns and reports draws (board full, no win).

Parameters:
- ROWS, 6, board rows; row 0 is the bottom.
- COLS, 7, board columns.
- CW, 3, column index width; must satisfy 2**CW >= COLS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- move_valid  in  1  drop request
- move_col  in  CW  target column
- move_ready  out  1  high only in IDLE; a move is accepted when move_valid && move_ready
- move_done  out  1  one-cycle pulse: piece written
- move_err  out  1  one-cycle pulse: move rejected, no state change
- board  out  2*ROWS*COLS  cell (r,c) at bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)]
- turn  out  1  0 = blue to move, 1 = red to move
- win_in  in  2  aggregated checker result: 00 none, 10 blue, 11 red
- game_over  out  1  game ended; all moves ignored
- result  out  2  00 in play, 10 blue win, 11 red win, 01 draw
- new_game  in  1  clears board, honoured in IDLE or OVER only

Behaviour:
- Cell codes: 00 empty, 10 blue, 11 red. 01 is never written to a cell.
- Reset (synchronous, rst high at a clock edge), from any state including mid-scan:
  - board all 00; turn=0; result=00; game_over=0; move_done=0; move_err=0; state=IDLE.
- States: IDLE, SCAN, WRITE, SETTLE, OVER.
- IDLE:
  - move_ready=1.
  - On accept with move_col >= COLS: move_err pulses the next cycle, state stays IDLE.
  - On accept with a valid column: latch the column, row index = 0, go to SCAN.
- SCAN (one row per cycle):
  - Cell (row, col) == 00: go to WRITE.
  - Cell occupied and row == ROWS-1 (column full): move_err pulses, return to IDLE; board and turn unchanged.
  - Otherwise: row increments.
- WRITE:
  - Cell <= {1'b1, turn}.
  - Move counter increments.
  - turn toggles.
  - Go to SETTLE.
- SETTLE:
  - Gives the combinational checkers one cycle to see the new board.
  - move_done pulses.
  - Samples win_in:
    - win_in == 10 or 11: result <= win_in, go to OVER.
    - else if move counter == ROWS*COLS: result <= 01, go to OVER.
    - else: go to IDLE.
- OVER:
  - game_over=1, move_ready=0.
  - move_valid is ignored: no err, no done.
- Latency from accept to move_done pulse: landing_row + 3 cycles.
  - Example: empty column → accept at cycle t, done at t+3.
- new_game:
  - In IDLE or OVER: acts like rst on the next edge.
  - In SCAN, WRITE or SETTLE: ignored.
  - If it coincides with an accept in IDLE, new_game wins and the move is dropped.
- Move counter: width ceil(log2(ROWS*COLS+1)); it never wraps.

Optional Feature:
- Macro: BOARD_WRITER_UNDO_EN.
- With the macro:
  - Add input port undo (1 bit).
  - An undo pulse in IDLE with a recorded last move clears that cell, toggles turn back and decrements the counter, all in one cycle, with no done pulse.
  - Only one level of undo is kept: the history entry is invalidated after an undo and at reset.
  - undo in any other state, or with no history: ignored.
  - undo and move_valid in the same IDLE cycle: undo has priority, and move_ready is low that cycle.
  - undo is illegal in OVER.
- Without the macro: the undo port does not exist and no history register is built.

Decomposition:
- Shared package (connect4_pkg):
  - Cell code constants CELL_EMPTY=2'b00, CELL_BLUE=2'b10, CELL_RED=2'b11.
  - Result constants RES_NONE, RES_BLUE, RES_RED, RES_DRAW=2'b01.
  - Default ROWS/COLS.
  - FSM state encoding.
- No sub-module is needed; the scan FSM and the board register stay in one module.
- The checker array remains external.

Test Plan:
- Reset, then drop col 3 → move_done at accept+3; bits of cell (0,3) = 10; turn=1.
- Drop col 3 six times, then a seventh → the seventh gives move_err at accept+7 (six scan cycles plus one); board and turn unchanged.
- move_col=7 → move_err the next cycle; state IDLE.
- Blue drops 0,1,2,3 alternating with red in col 6; the bench drives win_in=10 when the fourth blue lands → result=10, game_over=1; further moves ignored.
- Fill all 42 cells with win_in held at 00 → after the 42nd done: result=01, game_over=1.
- Assert rst during SCAN → next cycle the board is all 00, turn=0, move_ready=1, no done or err pulse.
- With BOARD_WRITER_UNDO_EN: drop col 2, then undo → cell (0,2)=00, turn=0; a second undo is ignored.
